// File: rtl/sar_search_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sar_search_ctrl_if                                              |
// | Brief    : Operand/flag bus between the search controller and a comparator |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface sar_search_ctrl_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] guess;
    logic             A_lt_B;
    logic             A_gt_B;
    logic             A_eq_B;

    modport master (output guess, input A_lt_B, input A_gt_B, input A_eq_B);
    modport slave  (input guess, output A_lt_B, output A_gt_B, output A_eq_B);
endinterface
`default_nettype wire

// File: rtl/sar_search_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sar_search_ctrl                                                 |
// | Brief    : Binary-search controller probing an external comparator.        |
// |            Optional macro SAR_STEP_CNT_EN adds the 'probes' counter port.  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module sar_search_ctrl #(
    parameter int WIDTH = 4
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             start,
    sar_search_ctrl_if.master     cmp,
    output logic                  busy,
    output logic                  done,
    output logic                  found,
    output logic                  err,
    output logic [WIDTH-1:0]      result
`ifdef SAR_STEP_CNT_EN
    ,
    output logic [WIDTH:0]        probes
`endif
);

    localparam logic [WIDTH:0]   c_MAX   = {1'b0, {WIDTH{1'b1}}};
    localparam logic [WIDTH-1:0] c_FIRST = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH:0]   c_ONE   = (WIDTH+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PROBE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [WIDTH:0]     r_lo;
    logic [WIDTH:0]     r_hi;
    logic [WIDTH-1:0]   r_guess;
    logic [WIDTH:0]     w_lo_new;
    logic [WIDTH:0]     w_hi_new;
    logic [WIDTH+1:0]   w_sum;
    logic [WIDTH-1:0]   w_mid;
    logic               w_onehot;
    logic               w_empty;
`ifdef SAR_STEP_CNT_EN
    logic [WIDTH:0]     r_probes;
`endif

    assign cmp.guess = r_guess;
    assign busy      = (r_state == S_PROBE);
    assign done      = (r_state == S_DONE);

    // Bounds are one bit wider than guess so lo may reach 2^WIDTH; a 'greater'
    // verdict at guess 0 would wrap hi, so it is caught explicitly.
    always_comb begin
        w_onehot = $onehot({cmp.A_lt_B, cmp.A_gt_B, cmp.A_eq_B});
        w_lo_new = r_lo;
        w_hi_new = r_hi;
        if (cmp.A_lt_B) w_lo_new = {1'b0, r_guess} + c_ONE;
        if (cmp.A_gt_B) w_hi_new = {1'b0, r_guess} - c_ONE;
        w_empty  = (cmp.A_gt_B && (r_guess == '0)) || (w_lo_new > w_hi_new);
        w_sum    = {1'b0, w_lo_new} + {1'b0, w_hi_new};
        w_mid    = WIDTH'(w_sum >> 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_PROBE;
            S_PROBE: if (!w_onehot || cmp.A_eq_B || w_empty) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lo     <= '0;
            r_hi     <= '0;
            r_guess  <= '0;
            found    <= 1'b0;
            err      <= 1'b0;
            result   <= '0;
`ifdef SAR_STEP_CNT_EN
            r_probes <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_lo     <= '0;
                        r_hi     <= c_MAX;
                        r_guess  <= c_FIRST;
                        found    <= 1'b0;
                        err      <= 1'b0;
                        result   <= '0;
`ifdef SAR_STEP_CNT_EN
                        r_probes <= '0;
`endif
                    end
                end
                S_PROBE: begin
`ifdef SAR_STEP_CNT_EN
                    r_probes <= r_probes + c_ONE;
`endif
                    if (!w_onehot) begin
                        err   <= 1'b1;
                        found <= 1'b0;
                    end else if (cmp.A_eq_B) begin
                        result <= r_guess;
                        found  <= 1'b1;
                    end else begin
                        r_lo  <= w_lo_new;
                        r_hi  <= w_hi_new;
                        found <= 1'b0;
                        if (!w_empty) r_guess <= w_mid;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SAR_STEP_CNT_EN
    assign probes = r_probes;
`endif

endmodule
`default_nettype wire
